ahb_sram_slave: RTL and testbench

AHB-Lite responder that terminates the transfers issued by the team's AHB master interface and backs them with an on-chip word-addressed SRAM array. It sits on the slave side of the bus, behind the address decoder's select line. It runs the pipelined address/data-phase protocol with optional wait states and a two-cycle ERROR response. It supports byte, halfword and word accesses with little-endian lane selection.

---
 rtl/ahb_sram_slave.sv | 161 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-addressed SRAM with byte/halfword/word lanes.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES HREADYOUT-low cycles per OKAY data phase.
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk_i,
    input  logic        hreset_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [2:0]  hburst_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hreadyout_o,
    output logic [1:0]  hresp_o,
    output logic [31:0] hrdata_o
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StErr1,
        StErr2
`ifdef AHB_SLV_WAIT_EN
        , StWait
`endif
    } state_e;

    state_e         state_q, state_d, acc_state;
    logic [AW-1:0]  idx_q, idx_d;
    logic [1:0]     lane_q, lane_d;
    logic [1:0]     size_q, size_d;
    logic           write_q, write_d;
    logic           ready_int;
    logic           accept;
    logic           addr_err, size_err, align_err, req_err;
    logic           mem_we;
    logic [3:0]     be;
    logic [31:0]    mem_q [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{hburst_i, htrans_i[0], WAIT_STATES[0]};

`ifdef AHB_SLV_WAIT_EN
    logic [2:0] wcnt_q, wcnt_d;
    assign ready_int = (state_q != StErr1) && (state_q != StWait);
`else
    assign ready_int = (state_q != StErr1);
`endif

    // Only sample a new address phase when this slave is not stalling the bus.
    assign accept = hsel_i & hready_i & htrans_i[1] & ready_int;

    assign addr_err  = |haddr_i[31:AW+2];
    assign size_err  = hsize_i[2] | (hsize_i[1:0] == 2'b11);
    assign align_err = ((hsize_i == 3'b001) & haddr_i[0]) |
                       ((hsize_i == 3'b010) & (|haddr_i[1:0]));
    assign req_err   = addr_err | size_err | align_err;

    always_comb begin
        acc_state = StData;
        if (req_err) begin
            acc_state = StErr1;
        end
`ifdef AHB_SLV_WAIT_EN
        else if (WAIT_STATES > 0) begin
            acc_state = StWait;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
`ifdef AHB_SLV_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            StIdle, StData, StErr2: begin
                state_d = accept ? acc_state : StIdle;
            end
`ifdef AHB_SLV_WAIT_EN
            StWait: begin
                if (wcnt_q == '0) begin
                    state_d = StData;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
`endif
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            idx_d   = haddr_i[AW+1:2];
            lane_d  = haddr_i[1:0];
            size_d  = hsize_i[1:0];
            write_d = hwrite_i;
`ifdef AHB_SLV_WAIT_EN
            wcnt_d  = 3'(WAIT_STATES - 1);
`endif
        end
    end

    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
`ifdef AHB_SLV_WAIT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'b00:   be[lane_q] = 1'b1;
            2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Reset forces state_q to StIdle asynchronously, so a pending write never commits.
    assign mem_we = (state_q == StData) && write_q;

    always_ff @(posedge hclk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout_o = ready_int;
    assign hresp_o     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
    assign hrdata_o    = ((state_q == StData) && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: reset, lanes, wait states, errors, bursts, idle.
module tb_ahb_sram_slave;

    localparam int unsigned MemDepth = 64;
`ifdef AHB_SLV_WAIT_EN
    localparam int ExpWait = 2;
`else
    localparam int ExpWait = 0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_force;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] t_addr  [8];
    logic [31:0] t_wdata [8];
    logic        t_wr    [8];
    logic [2:0]  t_size  [8];
    logic [1:0]  t_trans [8];
    int          r_waits   [8];
    logic [1:0]  r_resp    [8];
    logic [1:0]  r_lowresp [8];
    logic [31:0] r_rdata   [8];

    always #5 hclk = ~hclk;

    assign hready = hready_force ? 1'b0 : hreadyout;

    ahb_sram_slave #(
        .MEM_DEPTH  (MemDepth),
        .WAIT_STATES(2)
    ) dut (
        .hclk_i     (hclk),
        .hreset_i   (hreset),
        .hsel_i     (hsel),
        .haddr_i    (haddr),
        .htrans_i   (htrans),
        .hwrite_i   (hwrite),
        .hsize_i    (hsize),
        .hburst_i   (hburst),
        .hwdata_i   (hwdata),
        .hready_i   (hready),
        .hreadyout_o(hreadyout),
        .hresp_o    (hresp),
        .hrdata_o   (hrdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_t(input int i, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [1:0] trans,
                         input logic [31:0] wdata);
        t_addr[i]  = addr;
        t_wr[i]    = wr;
        t_size[i]  = size;
        t_trans[i] = trans;
        t_wdata[i] = wdata;
    endtask

    task automatic drive_addr(input int i);
        hsel   = 1'b1;
        htrans = t_trans[i];
        haddr  = t_addr[i];
        hwrite = t_wr[i];
        hsize  = t_size[i];
        hburst = 3'b011;
    endtask

    // Pipelined driver: next address phase overlaps the current data phase.
    task automatic run_seq(input int n);
        int   aph;
        int   dph;
        int   done;
        logic rdy;
        aph  = 0;
        dph  = -1;
        done = 0;
        for (int k = 0; k < n; k++) begin
            r_waits[k]   = 0;
            r_resp[k]    = 2'b11;
            r_lowresp[k] = 2'b00;
            r_rdata[k]   = 32'hDEAD_DEAD;
        end
        @(posedge hclk); #1;
        drive_addr(0);
        for (int cyc = 0; cyc < 200 && done < n; cyc++) begin
            @(negedge hclk);
            rdy = hreadyout;
            if (dph >= 0) begin
                if (!rdy) begin
                    r_waits[dph]++;
                    r_lowresp[dph] = hresp;
                end else begin
                    r_resp[dph]  = hresp;
                    r_rdata[dph] = hrdata;
                    done++;
                end
            end
            @(posedge hclk); #1;
            if (rdy) begin
                dph = (aph < n) ? aph : -1;
                if (dph >= 0) hwdata = t_wdata[dph];
                aph++;
                if (aph < n) begin
                    drive_addr(aph);
                end else begin
                    hsel   = 1'b0;
                    htrans = 2'b00;
                end
            end
        end
        check("seq_done", done, n);
    endtask

    task automatic check_okay(input string tag, input int i);
        check({tag, "_resp"}, r_resp[i], 2'b00);
        check({tag, "_waits"}, r_waits[i], ExpWait);
    endtask

    task automatic check_err(input string tag, input int i);
        check({tag, "_waits"}, r_waits[i], 1);
        check({tag, "_resp1"}, r_lowresp[i], 2'b01);
        check({tag, "_resp2"}, r_resp[i], 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hreset       = 1'b1;
        hsel         = 1'b0;
        haddr        = '0;
        htrans       = 2'b00;
        hwrite       = 1'b0;
        hsize        = 3'b010;
        hburst       = 3'b000;
        hwdata       = '0;
        hready_force = 1'b0;
        #12;
        check("rst_hreadyout", hreadyout, 1'b1);
        check("rst_hresp", hresp, 2'b00);
        check("rst_hrdata", hrdata, 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;

        // Known value at 0x10, then a write aborted by reset.
        set_t(0, 32'h10, 1'b1, 3'b010, 2'b10, 32'h0BAD_F00D);
        run_seq(1);
        check_okay("pre_w10", 0);

        @(posedge hclk); #1;
        set_t(0, 32'h10, 1'b1, 3'b010, 2'b10, 32'hA5A5_A5A5);
        drive_addr(0);
        @(posedge hclk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 10 && !hreadyout; c++) begin
            @(posedge hclk); #1;
        end
        check("midrst_in_data", hreadyout, 1'b1);
        hreset = 1'b1;
        #1;
        check("midrst_hreadyout", hreadyout, 1'b1);
        check("midrst_hresp", hresp, 2'b00);
        check("midrst_hrdata", hrdata, 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        set_t(0, 32'h10, 1'b0, 3'b010, 2'b10, 32'h0);
        run_seq(1);
        check_okay("rd10", 0);
        check("rd10_data", r_rdata[0], 32'h0BAD_F00D);

        // Lane merging, back-to-back with read-after-write.
        set_t(0, 32'h20, 1'b1, 3'b010, 2'b10, 32'h1234_5678);
        set_t(1, 32'h21, 1'b1, 3'b000, 2'b10, 32'h0000_EE00);
        set_t(2, 32'h20, 1'b0, 3'b010, 2'b10, 32'h0);
        set_t(3, 32'h24, 1'b1, 3'b010, 2'b10, 32'h1122_3344);
        set_t(4, 32'h26, 1'b1, 3'b001, 2'b10, 32'hBEEF_0000);
        set_t(5, 32'h24, 1'b0, 3'b010, 2'b10, 32'h0);
        run_seq(6);
        check_okay("byte_rd", 2);
        check("byte_rd_data", r_rdata[2], 32'h1234_EE78);
        check_okay("half_rd", 5);
        check("half_rd_data", r_rdata[5], 32'hBEEF_3344);

        // Error responses leave word 0 untouched.
        set_t(0, 32'h0, 1'b1, 3'b010, 2'b10, 32'hCAFE_BABE);
        run_seq(1);
        set_t(0, MemDepth * 4, 1'b1, 3'b010, 2'b10, 32'hFFFF_FFFF);
        set_t(1, 32'h03, 1'b1, 3'b001, 2'b10, 32'hFFFF_FFFF);
        set_t(2, 32'h00, 1'b1, 3'b011, 2'b10, 32'hFFFF_FFFF);
        set_t(3, MemDepth * 4, 1'b0, 3'b010, 2'b10, 32'h0);
        set_t(4, 32'h00, 1'b0, 3'b010, 2'b10, 32'h0);
        run_seq(5);
        check_err("err_range", 0);
        check_err("err_align", 1);
        check_err("err_size", 2);
        check_err("err_rd", 3);
        check("err_rd_data", r_rdata[3], 32'h0);
        check_okay("err_chk", 4);
        check("err_chk_data", r_rdata[4], 32'hCAFE_BABE);

        // INCR4 write burst directly followed by INCR4 read burst.
        for (int i = 0; i < 4; i++) begin
            set_t(i, 32'h40 + 4 * i, 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11, i + 1);
            set_t(i + 4, 32'h40 + 4 * i, 1'b0, 3'b010, (i == 0) ? 2'b10 : 2'b11, 32'h0);
        end
        t_addr[4] = 32'h4C;
        t_addr[7] = 32'h40;
        run_seq(8);
        check("burst_rd4c", r_rdata[4], 32'd4);
        check("burst_rd44", r_rdata[5], 32'd2);
        check("burst_rd48", r_rdata[6], 32'd3);
        check("burst_rd40", r_rdata[7], 32'd1);
        check_okay("burst_rd", 7);

        // IDLE/BUSY selected, unselected NONSEQ, NONSEQ under external HREADY low.
        @(posedge hclk); #1;
        hsel   = 1'b1;
        htrans = 2'b00;
        hwrite = 1'b1;
        haddr  = 32'h40;
        hsize  = 3'b010;
        @(negedge hclk);
        check("idle_rdy", hreadyout, 1'b1);
        check("idle_resp", hresp, 2'b00);
        @(posedge hclk); #1;
        htrans = 2'b01;
        hwdata = 32'hFFFF_FFFF;
        @(negedge hclk);
        check("busy_rdy", hreadyout, 1'b1);
        @(posedge hclk); #1;
        htrans = 2'b00;
        @(negedge hclk);
        check("busy_after_rdy", hreadyout, 1'b1);
        @(posedge hclk); #1;
        hsel   = 1'b0;
        htrans = 2'b10;
        haddr  = 32'h40;
        @(posedge hclk); #1;
        htrans = 2'b00;
        @(negedge hclk);
        check("unsel_rdy", hreadyout, 1'b1);
        check("unsel_resp", hresp, 2'b00);
        @(posedge hclk); #1;
        hsel         = 1'b1;
        htrans       = 2'b10;
        haddr        = 32'h44;
        hready_force = 1'b1;
        @(posedge hclk); #1;
        hready_force = 1'b0;
        hsel         = 1'b0;
        htrans       = 2'b00;
        @(negedge hclk);
        check("nordy_rdy", hreadyout, 1'b1);
        @(posedge hclk); #1;
        hwdata = 32'h0;
        set_t(0, 32'h40, 1'b0, 3'b010, 2'b10, 32'h0);
        set_t(1, 32'h44, 1'b0, 3'b010, 2'b10, 32'h0);
        run_seq(2);
        check("idle_chk40", r_rdata[0], 32'd1);
        check("idle_chk44", r_rdata[1], 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
